// File: rtl/uart_dump_pkg.sv
// Shared types and defaults for the UART TXD line dumper.
package uart_dump_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_dump_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; latency 2 cycles, no backpressure.
// Both flops reset to 1 so an idle (high) line never looks like a start bit.
module uart_dump_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_dumper_core.sv
// 8N1 UART monitor receiver: byte + one-cycle DAV 154 cycles after start edge (defaults); no backpressure.
// Define UART_TX_DUMPER_PRINT_EN to echo received bytes / frame errors to stdout in simulation.
module uart_tx_dumper_core
  import uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_line,
  output logic                 UART_SR_DAV,
  output logic [DATA_BITS-1:0] UART_SR,
  output logic                 o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 line_s;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 dav_q, dav_d;
  logic                 ferr_q, ferr_d;

  uart_dump_sync2 u_sync (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_line),
    .q_o    (line_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sr_q    <= '0;
      dav_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sr_q    <= sr_d;
      dav_q   <= dav_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    sr_d    = sr_q;
    dav_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!line_s) state_d = START;
      end
      START: begin
        // Mid-start re-check filters glitches shorter than half a bit.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {line_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (line_s) begin
            sr_d    = shift_q;
            dav_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low (break) line must return high before another start is accepted.
        cnt_d = '0;
        if (line_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign UART_SR_DAV = dav_q;
  assign UART_SR     = sr_q;
  assign o_frame_err = ferr_q;

`ifdef UART_TX_DUMPER_PRINT_EN
  always @(posedge i_clk) begin
    if (dav_q) begin
      $write("%c", sr_q);
    end
    if (ferr_q) begin
      $write("<FERR>");
    end
  end
`else
`endif

endmodule

// File: tb/tb_uart_tx_dumper_core.sv
// Directed bench for uart_tx_dumper_core: reset, single frame latency, stream, glitch,
// framing error recovery and mid-frame reset.
module tb_uart_tx_dumper_core;

  logic       clk;
  logic       rst_n;
  logic       line;
  logic       dav;
  logic [7:0] sr;
  logic       ferr;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int dav_cyc = 0;
  int ferr_cnt = 0;
  int wide_cnt = 0;
  logic prev_dav = 1'b0;
  logic [7:0] rx_q[$];

  uart_tx_dumper_core dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_line      (line),
    .UART_SR_DAV (dav),
    .UART_SR     (sr),
    .o_frame_err (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dav) begin
      rx_q.push_back(sr);
      dav_cyc = cyc;
    end
    if (dav && prev_dav) wide_cnt++;
    if (ferr) ferr_cnt++;
    prev_dav = dav;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start, data (LSB first) and stop, stopping early after ncyc cycles.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int ncyc);
    logic [9:0] f;
    int k;
    f = {stop_bit, b, 1'b0};
    k = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (k >= ncyc) return;
        line = f[i];
        tick(1);
        k++;
      end
    end
  endtask

  initial begin
    int start_cyc;
    string s;
    s = "DLROW OLLEH ";
    rst_n = 1'b0;
    line  = 1'b1;

    // Reset with a toggling line.
    for (int i = 0; i < 20; i++) begin
      line = i[0];
      tick(1);
    end
    check("rst_dav", {31'd0, dav}, 32'd0);
    check("rst_sr", {24'd0, sr}, 32'h00);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_no_rx", rx_q.size(), 0);
    line  = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);

    // Single 'H' with latency from the first edge seeing the line low.
    rx_q.delete();
    start_cyc = cyc;
    drive_frame(8'h48, 1'b1, 160);
    line = 1'b1;
    tick(10);
    check("h_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("h_data", {24'd0, rx_q[0]}, 32'h48);
    check("h_latency", dav_cyc - (start_cyc + 1), 154);
    check("h_hold", {24'd0, sr}, 32'h48);

    // Back-to-back stream, no idle between frames.
    rx_q.delete();
    for (int i = 0; i < 12; i++) drive_frame(s[i], 1'b1, 160);
    line = 1'b1;
    tick(20);
    check("stream_count", rx_q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < rx_q.size()) check($sformatf("stream_%0d", i), {24'd0, rx_q[i]}, {24'd0, s[i]});
    check("stream_ferr", ferr_cnt, 0);

    // Start glitch rejected, then the receiver still decodes a frame.
    rx_q.delete();
    line = 1'b0;
    tick(3);
    line = 1'b1;
    tick(40);
    check("glitch_no_dav", rx_q.size(), 0);
    check("glitch_ferr", ferr_cnt, 0);
    drive_frame(8'h3C, 1'b1, 160);
    line = 1'b1;
    tick(10);
    check("post_glitch_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("post_glitch_data", {24'd0, rx_q[0]}, 32'h3C);

    // Stop bit low, line held low, then recovery.
    rx_q.delete();
    drive_frame(8'h55, 1'b0, 160);
    line = 1'b0;
    tick(100);
    check("ferr_pulse", ferr_cnt, 1);
    check("ferr_no_dav", rx_q.size(), 0);
    check("ferr_sr_kept", {24'd0, sr}, 32'h3C);
    line = 1'b1;
    tick(20);
    drive_frame(8'hA5, 1'b1, 160);
    line = 1'b1;
    tick(10);
    check("a5_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("a5_data", {24'd0, rx_q[0]}, 32'hA5);
    check("a5_ferr", ferr_cnt, 1);

    // Reset in the middle of data bit 4.
    rx_q.delete();
    drive_frame(8'h00, 1'b1, 16 * 5 + 8);
    rst_n = 1'b0;
    line  = 1'b1;
    tick(3);
    check("midrst_dav", {31'd0, dav}, 32'd0);
    check("midrst_sr", {24'd0, sr}, 32'h00);
    rst_n = 1'b1;
    tick(200);
    check("midrst_no_rx", rx_q.size(), 0);
    check("midrst_ferr", ferr_cnt, 1);
    drive_frame(8'h0F, 1'b1, 160);
    line = 1'b1;
    tick(10);
    check("0f_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("0f_data", {24'd0, rx_q[0]}, 32'h0F);
    check("dav_width", wide_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

endmodule
